// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 640x480@60 raster constants, colour layout and sync polarity
package video_timing_pkg;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam bit VGA_SYNC_ACTIVE = 1'b0;
    typedef logic [11:0] color_t;
    localparam int COMP_W = 4;
    localparam int R_LSB  = 8;
    localparam int G_LSB  = 4;
    localparam int B_LSB  = 0;
endpackage

// File: rtl/pix_delay_line.sv
// pix_delay_line: tick-enabled shift register; DEPTH=0 degenerates to a wire
module pix_delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    localparam int N = (DEPTH == 0) ? 1 : DEPTH;

    logic [WIDTH-1:0] r_pipe [N];

    // shift one stage per tick; unused single stage is optimised away when DEPTH=0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) r_pipe[i] <= RESET_VALUE;
        end else if (i_en) begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = (DEPTH == 0) ? i_d : r_pipe[N-1];
endmodule

// File: rtl/video_scan_timing.sv
// video_scan_timing: VGA raster counters, scan position outputs and sync-aligned RGB pins
module video_scan_timing
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter bit SYNC_ACTIVE = VGA_SYNC_ACTIVE,
    parameter int PIPE_STAGES = 0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_pix_en,
    input  color_t       i_color,
    output logic [8:0]   o_scan_row,
    output logic [9:0]   o_scan_column,
    output logic         o_active,
    output logic         o_line_start,
    output logic         o_frame_start,
    output logic [3:0]   o_vga_r,
    output logic [3:0]   o_vga_g,
    output logic [3:0]   o_vga_b,
    output logic         o_hsync,
    output logic         o_vsync
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    if (PIPE_STAGES < 0 || PIPE_STAGES > 4) begin : g_bad_pipe
        $error("PIPE_STAGES must be in 0..4");
    end
    if (V_VISIBLE > 512 || H_VISIBLE > 1024) begin : g_bad_size
        $error("visible area exceeds scan port widths");
    end

    logic [9:0] r_h, r_v;
    logic [9:0] w_h_next, w_v_next;
    logic       w_h_vis, w_v_vis, w_hs, w_vs;
    logic       r_hs_raw, r_vs_raw;
    logic       w_act_d, w_hs_d, w_vs_d;

    // next counter position and its raster decode, registered below on the same tick
    always_comb begin
        w_h_next = (r_h == H_LAST) ? '0 : r_h + 10'd1;
        w_v_next = (r_h != H_LAST) ? r_v : (r_v == V_LAST) ? '0 : r_v + 10'd1;
        w_h_vis  = w_h_next < H_VIS;
        w_v_vis  = w_v_next < V_VIS;
        w_hs     = (w_h_next >= HS_BEG) && (w_h_next < HS_END);
        w_vs     = (w_v_next >= VS_BEG) && (w_v_next < VS_END);
    end

    // raster counters: h wraps at line end, v advances on the h wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (i_pix_en) begin
            r_h <= w_h_next;
            r_v <= w_v_next;
        end
    end

    // scan outputs and raw syncs, all describing the counter state after the tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_scan_row    <= '0;
            o_scan_column <= '0;
            o_active      <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            r_hs_raw      <= ~SYNC_ACTIVE;
            r_vs_raw      <= ~SYNC_ACTIVE;
        end else if (i_pix_en) begin
            o_scan_row    <= w_v_vis ? w_v_next[8:0] : '0;
            o_scan_column <= w_h_vis ? w_h_next : '0;
            o_active      <= w_h_vis && w_v_vis;
            o_line_start  <= (w_h_next == '0);
            o_frame_start <= (w_h_next == '0) && (w_v_next == '0);
            r_hs_raw      <= w_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vs_raw      <= w_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    pix_delay_line #(
        .WIDTH       (3),
        .DEPTH       (PIPE_STAGES),
        .RESET_VALUE ({1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE})
    ) u_align (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_pix_en),
        .i_d     ({o_active, r_hs_raw, r_vs_raw}),
        .o_q     ({w_act_d, w_hs_d, w_vs_d})
    );

    // pin register: colour arrives matched to the delayed flags, blanked outside the visible area
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vga_r <= '0;
            o_vga_g <= '0;
            o_vga_b <= '0;
            o_hsync <= ~SYNC_ACTIVE;
            o_vsync <= ~SYNC_ACTIVE;
        end else if (i_pix_en) begin
            o_vga_r <= w_act_d ? i_color[R_LSB +: COMP_W] : '0;
            o_vga_g <= w_act_d ? i_color[G_LSB +: COMP_W] : '0;
            o_vga_b <= w_act_d ? i_color[B_LSB +: COMP_W] : '0;
            o_hsync <= w_hs_d;
            o_vsync <= w_vs_d;
        end
    end
endmodule

// File: tb/tb_video_scan_timing.sv
// tb_video_scan_timing: tick-count reference model checking three configurations every cycle
module tb_video_scan_timing;
    typedef struct packed {
        logic [8:0]  row;
        logic [9:0]  col;
        logic        act;
        logic        ls;
        logic        fs;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic pix_en = 1'b1;
    logic run = 1'b0;
    int   n = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // Expected outputs after n ticks since reset release: scan shows position n mod frame,
    // pins show position n-ps-1; tick 0 (and the reset-state raw flags) read as blank/idle.
    function automatic obs_t model(int k, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, int ps, bit sa);
        int ht, ft, pos, h, v, m;
        obs_t e;
        ht = hv + hf + hsw + hb;
        ft = ht * (vv + vf + vsw + vb);
        e = '0;
        e.hs = ~sa;
        e.vs = ~sa;
        if (k >= 1) begin
            pos = k % ft; h = pos % ht; v = pos / ht;
            e.act = (h < hv) && (v < vv);
            e.col = (h < hv) ? 10'(h) : 10'd0;
            e.row = (v < vv) ? 9'(v) : 9'd0;
            e.ls  = (h == 0);
            e.fs  = (pos == 0);
        end
        m = k - ps - 1;
        if (m >= 1) begin
            pos = m % ft; h = pos % ht; v = pos / ht;
            if (h < hv && v < vv) e.rgb = {4'(h), 4'(v), 4'h5};
            e.hs = (h >= hv + hf && h < hv + hf + hsw) ? sa : ~sa;
            e.vs = (v >= vv + vf && v < vv + vf + vsw) ? sa : ~sa;
        end
        return e;
    endfunction

    function automatic obs_t exp_a(int k);
        return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0);
    endfunction
    function automatic obs_t exp_b(int k);
        return model(k, 16, 2, 3, 3, 6, 1, 2, 2, 2, 1'b0);
    endfunction
    function automatic obs_t exp_c(int k);
        return model(k, 16, 2, 3, 3, 6, 1, 2, 2, 1, 1'b1);
    endfunction
    function automatic logic [11:0] stim(obs_t e);
        return {e.col[3:0], e.row[3:0], 4'h5};
    endfunction

    // reference tick counter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else if (pix_en) n <= n + 1;
    end

    logic [11:0] a_color, b_color, c_color;
    logic [8:0]  a_row, b_row, c_row;
    logic [9:0]  a_col, b_col, c_col;
    logic        a_act, b_act, c_act, a_ls, b_ls, c_ls, a_fs, b_fs, c_fs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic        a_hs, a_vs, b_hs, b_vs, c_hs, c_vs;

    // colour for the scan position issued PIPE_STAGES ticks earlier
    assign a_color = stim(exp_a(n));
    assign b_color = stim(exp_b(n - 2));
    assign c_color = stim(exp_c(n - 1));

    video_scan_timing u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_color(a_color),
        .o_scan_row(a_row), .o_scan_column(a_col), .o_active(a_act),
        .o_line_start(a_ls), .o_frame_start(a_fs),
        .o_vga_r(a_r), .o_vga_g(a_g), .o_vga_b(a_b), .o_hsync(a_hs), .o_vsync(a_vs)
    );

    video_scan_timing #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(1'b0), .PIPE_STAGES(2)
    ) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_color(b_color),
        .o_scan_row(b_row), .o_scan_column(b_col), .o_active(b_act),
        .o_line_start(b_ls), .o_frame_start(b_fs),
        .o_vga_r(b_r), .o_vga_g(b_g), .o_vga_b(b_b), .o_hsync(b_hs), .o_vsync(b_vs)
    );

    video_scan_timing #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(1'b1), .PIPE_STAGES(1)
    ) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_color(c_color),
        .o_scan_row(c_row), .o_scan_column(c_col), .o_active(c_act),
        .o_line_start(c_ls), .o_frame_start(c_fs),
        .o_vga_r(c_r), .o_vga_g(c_g), .o_vga_b(c_b), .o_hsync(c_hs), .o_vsync(c_vs)
    );

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = {a_row, a_col, a_act, a_ls, a_fs, a_r, a_g, a_b, a_hs, a_vs};
    assign obs_b = {b_row, b_col, b_act, b_ls, b_fs, b_r, b_g, b_b, b_hs, b_vs};
    assign obs_c = {c_row, c_col, c_act, c_ls, c_fs, c_r, c_g, c_b, c_hs, c_vs};

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got=%0h want=%0h", name, n, act, exp);
        end
    endtask

    task automatic wait_n(int t);
        int g = 0;
        while (n != t && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("reach_tick", 64'(n), 64'(t));
    endtask

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (run) begin
            check("dut_a", obs_a, exp_a(n));
            check("dut_b", obs_b, exp_b(n));
            check("dut_c", obs_c, exp_c(n));
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_a_hsync", a_hs, 1'b1);
        check("rst_c_hsync", c_hs, 1'b0);
        check("rst_c_vsync", c_vs, 1'b0);
        check("rst_b_active", b_act, 1'b0);
        rst_n = 1'b1;

        wait_n(21);  check("c_hsync_h19", c_hs, 1'b1);
        wait_n(55);  check("c_rgb_5_2", {c_r, c_g, c_b}, 12'h525);
        wait_n(56);  check("b_rgb_5_2", {b_r, b_g, b_b}, 12'h525);
        wait_n(135); check("b_last_vis", {b_row, b_col, b_act}, {9'd5, 10'd15, 1'b1});
        wait_n(136); check("b_h_blank", {b_row, b_col, b_act}, {9'd5, 10'd0, 1'b0});
        wait_n(147); check("b_v_blank", {b_row, b_col, b_act}, {9'd0, 10'd3, 1'b0});
        wait_n(263); check("b_fs_pre", b_fs, 1'b0);
        wait_n(264); check("b_fs_first", b_fs, 1'b1);
        wait_n(656); check("a_hs_pre", a_hs, 1'b1);
        wait_n(657); check("a_hs_start", a_hs, 1'b0);
        wait_n(752); check("a_hs_last", a_hs, 1'b0);
        wait_n(753); check("a_hs_end", a_hs, 1'b1);
        wait_n(799); check("a_ls_pre", a_ls, 1'b0);
        wait_n(800); check("a_ls", a_ls, 1'b1);
        wait_n(801); check("a_ls_post", a_ls, 1'b0);
        wait_n(2000);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            pix_en = (i % 2 == 0);
        end
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            pix_en = (i % 4 == 0);
        end
        @(negedge clk);
        pix_en = 1'b1;

        begin
            int g = 0;
            while (n % 800 != 700 && g < 2000) begin
                @(negedge clk);
                g++;
            end
        end
        check("mid_reach", 64'(n % 800), 64'd700);
        check("mid_a_hsync_on", a_hs, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_a_hsync_off", a_hs, 1'b1);
        check("mid_a_scan", {a_row, a_col, a_act}, '0);
        check("mid_rgb", {a_r, a_g, a_b, b_r, b_g, b_b}, '0);
        check("mid_c_hsync", c_hs, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_n(263); check("b_fs_re_pre", b_fs, 1'b0);
        wait_n(264); check("b_fs_re", b_fs, 1'b1);
        wait_n(400);
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
